// File: rtl/cordic_table_loader.sv
// Writer side of the CORDIC/DDS coefficient-table port: packs three 16-bit beats into
// each 48-bit table word, writes DEPTH entries from index 0, then enables the core.
module cordic_table_loader #(
  parameter int DEPTH  = 64,
  parameter int IDX_W  = 6,
  parameter int BEAT_W = 16,
  localparam int WORD_W = 3 * BEAT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [BEAT_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wen,
  output logic [IDX_W-1:0]  index_wri,
  output logic [WORD_W-1:0] D,
  output logic              cen,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] checksum
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST_ENTRY = IDX_W'(DEPTH - 1);

  state_t              state;
  logic [1:0]          beat;
  logic [IDX_W-1:0]    entry;
  logic [2*BEAT_W-1:0] acc;

  logic beat_fire;
  assign beat_fire = in_valid && in_ready;

  // NOTE: every register, including the beat accumulator, is reset so no X can reach
  // the table port or the checksum even if the first load is abandoned.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      beat      <= '0;
      entry     <= '0;
      acc       <= '0;
      in_ready  <= 1'b0;
      wen       <= 1'b0;
      index_wri <= '0;
      D         <= '0;
      cen       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      checksum  <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout; strobes default low and are
      // overridden below, so each one lasts exactly one cycle.
      wen  <= 1'b0;
      done <= 1'b0;

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= COLLECT;
            checksum <= '0;
            entry    <= '0;
            beat     <= '0;
            cen      <= 1'b0;
            busy     <= 1'b1;
            in_ready <= 1'b1;
          end
        end

        COLLECT: begin
          // Beats arrive most-significant first; the third completes the word directly.
          if (beat_fire) begin
            case (beat)
              2'd0: begin
                acc[2*BEAT_W-1:BEAT_W] <= in_data;
                beat                   <= 2'd1;
              end
              2'd1: begin
                acc[BEAT_W-1:0] <= in_data;
                beat            <= 2'd2;
              end
              default: begin
                D         <= {acc, in_data};
                index_wri <= entry;
                wen       <= 1'b1;
                in_ready  <= 1'b0;
                beat      <= '0;
                state     <= WRITE;
              end
            endcase
          end
        end

        WRITE: begin
          checksum <= checksum ^ D;
          if (entry == LAST_ENTRY) begin
            state <= DONE;
            done  <= 1'b1;
            cen   <= 1'b1;
            busy  <= 1'b0;
          end else begin
            entry    <= entry + 1'b1;
            in_ready <= 1'b1;
            state    <= COLLECT;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
